// File: rtl/smpl_pkg.sv
// Shared types and constants for the capture-RAM unpacker.
package smpl_pkg;

    localparam int SMPL_PER_WORD = 4;
    localparam int WORD_W        = 8;
    localparam int SLOT_W        = $clog2(SMPL_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        STREAM,
        FIN
    } unpk_state_t;

endpackage

// File: rtl/smpl_shift.sv
// Holds one packed capture word and walks through its four (H,L) pairs, oldest pair first.
module smpl_shift
    import smpl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              advance,
    output logic              smpl_h,
    output logic              smpl_l,
    output logic              first_slot,
    output logic              last_slot
);

    logic [WORD_W-1:0] word;
    logic [SLOT_W-1:0] slot;

    // A load restarts at pair [1:0]; each advance steps to the next newer pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            slot <= '0;
        end else if (load) begin
            word <= load_word;
            slot <= '0;
        end else if (advance) begin
            slot <= slot + 1'b1;
        end
    end

    assign smpl_h     = word[{slot, 1'b1}];
    assign smpl_l     = word[{slot, 1'b0}];
    assign first_slot = (slot == '0);
    assign last_slot  = (slot == SLOT_W'(SMPL_PER_WORD - 1));

endmodule

// File: rtl/smpl_unpack.sv
// Reads packed H/L words back from the circular capture RAM and streams one sample per handshake.
module smpl_unpack
    import smpl_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_cnt,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              smpl_vld,
    input  logic              smpl_rdy,
    output logic              smpl_H,
    output logic              smpl_L,
    output logic              smpl_last,
    output logic              busy,
    output logic              done
);

    unpk_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W:0]   rd_left;
    logic [WORD_W-1:0] pbuf;
    logic              pbuf_vld;
    logic              rd_pend;

    logic              sh_load;
    logic              sh_adv;
    logic [WORD_W-1:0] sh_word;
    logic              sh_h;
    logic              sh_l;
    logic              sh_first;
    logic              sh_last;
    logic              last_word;

    smpl_shift u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .load_word  (sh_word),
        .advance    (sh_adv),
        .smpl_h     (sh_h),
        .smpl_l     (sh_l),
        .first_slot (sh_first),
        .last_slot  (sh_last)
    );

    assign addr_inc  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    // No word waiting or in flight means the word in the shifter is the final one.
    assign last_word = !pbuf_vld && !rd_pend;

    assign smpl_H    = (state == STREAM) && sh_h;
    assign smpl_L    = (state == STREAM) && sh_l;
    assign smpl_last = (state == STREAM) && sh_last && last_word;

    // Next-state and control decode; the prefetch read is issued as the first pair of a word is taken.
    always_comb begin
        state_nxt = state;
        ram_rd_en = 1'b0;
        ram_addr  = '0;
        sh_load   = 1'b0;
        sh_adv    = 1'b0;
        sh_word   = ram_rdata;
        smpl_vld  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_cnt == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                ram_rd_en = 1'b1;
                ram_addr  = addr_q;
                state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                sh_load   = 1'b1;
                sh_word   = ram_rdata;
                state_nxt = STREAM;
            end
            STREAM: begin
                busy     = 1'b1;
                smpl_vld = 1'b1;
                if (smpl_rdy) begin
                    if (sh_first && (rd_left != '0)) begin
                        ram_rd_en = 1'b1;
                        ram_addr  = addr_inc;
                    end
                    if (sh_last) begin
                        if (last_word) begin
                            state_nxt = FIN;
                        end else begin
                            sh_load = 1'b1;
                            sh_word = pbuf;
                        end
                    end else begin
                        sh_adv = 1'b1;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, read address/remaining-read count and the one-word prefetch buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            rd_left  <= '0;
            pbuf     <= '0;
            pbuf_vld <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= (state == STREAM) && ram_rd_en;
            if ((state == IDLE) && start) begin
                addr_q  <= start_addr;
                rd_left <= (word_cnt == '0) ? '0 : word_cnt - 1'b1;
            end else if ((state == STREAM) && ram_rd_en) begin
                addr_q  <= addr_inc;
                rd_left <= rd_left - 1'b1;
            end
            if (rd_pend) begin
                pbuf     <= ram_rdata;
                pbuf_vld <= 1'b1;
            end else if (((state == STREAM) && sh_load) || ((state == IDLE) && start)) begin
                pbuf_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_smpl_unpack.sv
// Self-checking bench for smpl_unpack: table-driven dumps, random dumps and reset/restart corners.
module tb_smpl_unpack;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 384;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   word_cnt;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic              smpl_vld;
    logic              smpl_rdy;
    logic              smpl_H;
    logic              smpl_L;
    logic              smpl_last;
    logic              busy;
    logic              done;

    logic [7:0] mem [0:511];
    logic [2:0] obs_q [$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int sa;
        int cnt;
        bit rnd;
        int restart_at;
        int exp_done;
    } vec_t;

    smpl_unpack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_cnt   (word_cnt),
        .ram_rd_en  (ram_rd_en),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .smpl_vld   (smpl_vld),
        .smpl_rdy   (smpl_rdy),
        .smpl_H     (smpl_H),
        .smpl_L     (smpl_L),
        .smpl_last  (smpl_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Capture RAM: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Runs one dump and checks every cycle against a queue-based model of the ring contents.
    task automatic applyStimulus(input int sa, input int cnt, input bit rnd, input int restart_at, input int exp_done);
        logic [2:0] exp_q [$];
        int exp_addr [$];
        logic [7:0] wd;
        logic [2:0] cur, prev_data;
        bit prev_hold, exp_busy, exp_dn;
        int cyc, first_vld, last_acc, done_cyc, reads, budget;
        for (int w = 0; w < cnt; w++) begin
            exp_addr.push_back((sa + w) % DEPTH);
            wd = mem[(sa + w) % DEPTH];
            for (int k = 0; k < 4; k++)
                exp_q.push_back({wd[2*k+1], wd[2*k], (w == cnt - 1) && (k == 3)});
        end
        obs_q.delete();
        first_vld = -1; last_acc = -1; done_cyc = -1; reads = 0; prev_hold = 0; prev_data = '0;
        budget = 16 * cnt + 20;
        @(negedge clk);
        start = 1'b1; start_addr = ADDR_W'(sa); word_cnt = (ADDR_W+1)'(cnt); smpl_rdy = 1'b1;
        for (cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (start) begin
                start_addr = ADDR_W'((sa + 100) % DEPTH);
                word_cnt   = 3;
            end
            smpl_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            exp_busy = (exp_q.size() != 0);
            exp_dn   = (cnt == 0) ? (cyc == 1) : (exp_q.size() == 0 && last_acc == cyc - 1);
            checkOutput("busy", busy, exp_busy);
            checkOutput("done", done, exp_dn);
            if (ram_rd_en) begin
                reads++;
                if (exp_addr.size() > 0) checkOutput("ram_addr", ram_addr, exp_addr.pop_front());
            end
            cur = {smpl_H, smpl_L, smpl_last};
            if (prev_hold) begin
                checkOutput("hold vld", smpl_vld, 1'b1);
                checkOutput("hold data", cur, prev_data);
            end
            if (smpl_vld) begin
                if (first_vld < 0) first_vld = cyc;
                if (exp_q.size() > 0) checkOutput("sample", cur, exp_q[0]);
                if (smpl_rdy) begin
                    obs_q.push_back(cur);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    last_acc = cyc;
                end
            end
            prev_hold = smpl_vld && !smpl_rdy;
            prev_data = cur;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) $display("[TB] FAIL timeout: no done within %0d cycles", budget);
        checkOutput("done cycle", done_cyc, (exp_done >= 0) ? exp_done : last_acc + 1);
        checkOutput("sample count", obs_q.size(), 4 * cnt);
        checkOutput("read count", reads, cnt);
        if (!rnd && cnt > 0) begin
            checkOutput("first vld latency", first_vld, 3);
            checkOutput("gap-free span", last_acc - first_vld + 1, 4 * cnt);
        end
        if (cnt == 0) checkOutput("vld for empty dump", first_vld, -1);
        @(negedge clk); #1;
        checkOutput("idle after done", {busy, done, smpl_vld, ram_rd_en}, 4'b0000);
    endtask

    initial begin
        vec_t vecs [8];
        logic [2:0] t1_exp [4];
        vecs[0] = '{5,   3,   1'b0, 0, 15};
        vecs[1] = '{383, 2,   1'b0, 0, 11};
        vecs[2] = '{10,  4,   1'b1, 0, -1};
        vecs[3] = '{20,  0,   1'b0, 0, 1};
        vecs[4] = '{30,  3,   1'b0, 6, 15};
        vecs[5] = '{200, 5,   1'b1, 9, -1};
        vecs[6] = '{382, 4,   1'b1, 0, -1};
        vecs[7] = '{7,   384, 1'b0, 0, 1539};
        t1_exp[0] = 3'b000; t1_exp[1] = 3'b010; t1_exp[2] = 3'b100; t1_exp[3] = 3'b111;

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'b11_10_01_00;

        rst = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0; smpl_rdy = 1'b0; ram_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset outputs",
                    {ram_rd_en, ram_addr, smpl_vld, smpl_H, smpl_L, smpl_last, busy, done}, '0);
        start = 1'b1; word_cnt = 2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        checkOutput("start under rst ignored", {busy, done, ram_rd_en, smpl_vld}, 4'b0000);

        $display("[TB] single word from addr 0");
        applyStimulus(0, 1, 1'b0, 0, 7);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("word0 pair%0d", k), (k < obs_q.size()) ? obs_q[k] : 3'bxxx, t1_exp[k]);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].sa, vecs[i].cnt, vecs[i].rnd, vecs[i].restart_at, vecs[i].exp_done);

        $display("[TB] random dumps");
        for (int i = 0; i < 6; i++)
            applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(1, 8), 1'b1, 0, -1);

        $display("[TB] reset mid-stream");
        @(negedge clk);
        start = 1'b1; start_addr = 50; word_cnt = 4; smpl_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("streaming before rst", smpl_vld, 1'b1);
        rst = 1'b1;
        @(negedge clk); #1;
        checkOutput("outputs after rst",
                    {ram_rd_en, ram_addr, smpl_vld, smpl_H, smpl_L, smpl_last, busy, done}, '0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            checkOutput("quiet after abort", {done, busy, smpl_vld, ram_rd_en}, 4'b0000);
        end
        applyStimulus(60, 2, 1'b0, 0, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
